// File: rtl/mcb_avl_wrap_seg.sv
// mcb_avl_wrap_seg: Avalon-MM burst slave to MCB command/data back-end bridge.
// An Avalon burst is split into aligned MCB commands of up to MCB_GRP_MAX
// 4-beat groups. Commands never cross a row end. Beats outside the burst
// window are masked: wbe=0 on writes, and no readdatavalid on reads.
// Each outstanding read command is tracked by a tag in a small FIFO.
// Ports:
//   csi_clockreset_clk/_reset  clock, asynchronous active-high reset
//   avs_s1_*                   Avalon-MM burst slave
//   mcb_bb/wr_n/bl/ba/ra/ca    registered MCB command (bb is a 1-cycle strobe)
//   mcb_busy, mcb_i_ready      back-end flow control / init done
//   mcb_wdat_req, mcb_wdat/wbe write data pulled one cycle after each req
//   mcb_rdat_vld, mcb_rdat     read data returned from the back-end
//   err_unexp_rdat             sticky: read data with no outstanding tag
module mcb_avl_wrap_seg #(
  parameter int unsigned AVL_A_W     = 24,
  parameter int unsigned AVL_D_W     = 32,
  parameter int unsigned AVL_BE_W    = 4,
  parameter int unsigned AVL_BC_W    = 6,
  parameter int unsigned MCB_B_W     = 2,
  parameter int unsigned MCB_R_W     = 13,
  parameter int unsigned MCB_C_W     = 9,
  parameter int unsigned MCB_GRP_MAX = 4,
  parameter int unsigned RDQ_DEPTH   = 8
) (
  input  logic                csi_clockreset_clk,
  input  logic                csi_clockreset_reset,
  input  logic [AVL_A_W-1:0]  avs_s1_address,
  input  logic                avs_s1_read,
  input  logic                avs_s1_write,
  input  logic                avs_s1_beginbursttransfer,
  input  logic [AVL_BC_W-1:0] avs_s1_burstcount,
  input  logic [AVL_D_W-1:0]  avs_s1_writedata,
  input  logic [AVL_BE_W-1:0] avs_s1_byteenable,
  output logic                avs_s1_waitrequest,
  output logic [AVL_D_W-1:0]  avs_s1_readdata,
  output logic                avs_s1_readdatavalid,
  output logic                mcb_bb,
  output logic                mcb_wr_n,
  output logic [1:0]          mcb_bl,
  output logic [MCB_B_W-1:0]  mcb_ba,
  output logic [MCB_R_W-1:0]  mcb_ra,
  output logic [MCB_C_W-1:0]  mcb_ca,
  input  logic                mcb_busy,
  input  logic                mcb_i_ready,
  input  logic                mcb_wdat_req,
  output logic [AVL_D_W-1:0]  mcb_wdat,
  output logic [AVL_BE_W-1:0] mcb_wbe,
  input  logic                mcb_rdat_vld,
  input  logic [AVL_D_W-1:0]  mcb_rdat,
  output logic                err_unexp_rdat
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WDAT  = 2'd2;
  localparam int unsigned PTR_W = $clog2(RDQ_DEPTH);

  // Beat k of a 4*grp-beat command is inside the burst window iff off <= k < off+vld.
  function automatic logic in_win(input logic [3:0] k, input logic [1:0] off,
                                  input logic [4:0] vld);
    logic [4:0] k5, lo;
    k5 = {1'b0, k};
    lo = {3'b000, off};
    return (k5 >= lo) && (k5 < lo + vld);
  endfunction

  logic [1:0]          st_q, st_d;
  logic [AVL_A_W-1:0]  addr_q, addr_d;
  logic [AVL_BC_W-1:0] rem_q, rem_d;
  logic                rd_q, rd_d, first_q, first_d;
  logic [2:0]          seg_grp_q, seg_grp_d, w_grp_q, w_grp_d;
  logic [1:0]          seg_off_q, seg_off_d, w_off_q, w_off_d;
  logic [4:0]          seg_vld_q, seg_vld_d, w_vld_q, w_vld_d;
  logic [3:0]          k_q, k_d, j_q, j_d;
  logic                wact_q, wact_d, wval_q, wval_d;
  logic                cmd_bb_q, cmd_bb_d, cmd_wr_n_q, cmd_wr_n_d;
  logic [1:0]          cmd_bl_q, cmd_bl_d;
  logic [MCB_B_W-1:0]  cmd_ba_q, cmd_ba_d;
  logic [MCB_R_W-1:0]  cmd_ra_q, cmd_ra_d;
  logic [MCB_C_W-1:0]  cmd_ca_q, cmd_ca_d;
  logic                rdv_q, rdv_d, err_q, err_d;
  logic [AVL_D_W-1:0]  rdata_q, rdata_d;
  logic [PTR_W:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [9:0]          mem_q [RDQ_DEPTH];
  logic [9:0]          head;
  logic                fifo_full, fifo_empty, push, pop, accept, fire;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                      (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign head       = mem_q[rptr_q[PTR_W-1:0]];

  assign accept = (st_q == ST_IDLE) & avs_s1_beginbursttransfer &
                  (avs_s1_read | avs_s1_write) & mcb_i_ready & (avs_s1_burstcount != '0);
  assign fire   = (st_q == ST_ISSUE) & ~mcb_busy & (~rd_q | ~fifo_full);

  // Segment of the next state's address/remaining count, so seg_*_q always matches addr_q/rem_q.
  always_comb begin
    int unsigned off_v, need_v, room_v, grp_v, vld_v;
    off_v  = 32'(addr_d[1:0]);
    need_v = (off_v + 32'(rem_d) + 32'd3) / 32'd4;
    room_v = (32'd1 << (MCB_C_W - 2)) - 32'(addr_d[MCB_C_W-1:2]);
    grp_v  = need_v;
    if (grp_v > MCB_GRP_MAX) grp_v = MCB_GRP_MAX;
    if (grp_v > room_v) grp_v = room_v;
    vld_v = 32'd4 * grp_v - off_v;
    if (vld_v > 32'(rem_d)) vld_v = 32'(rem_d);
    seg_grp_d = 3'(grp_v);
    seg_off_d = addr_d[1:0];
    seg_vld_d = 5'(vld_v);
  end

  always_comb begin
    st_d = st_q; addr_d = addr_q; rem_d = rem_q; rd_d = rd_q; first_d = first_q;
    w_grp_d = w_grp_q; w_off_d = w_off_q; w_vld_d = w_vld_q; k_d = k_q;
    wact_d = 1'b0; wval_d = 1'b0; push = 1'b0;
    cmd_bb_d = 1'b0; cmd_wr_n_d = cmd_wr_n_q; cmd_bl_d = cmd_bl_q;
    cmd_ba_d = cmd_ba_q; cmd_ra_d = cmd_ra_q; cmd_ca_d = cmd_ca_q;
    case (st_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = avs_s1_address;
          rem_d   = avs_s1_burstcount;
          rd_d    = avs_s1_read;
          first_d = 1'b1;
          st_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (fire) begin
          cmd_bb_d   = 1'b1;
          cmd_wr_n_d = rd_q;
          cmd_bl_d   = 2'(seg_grp_q - 3'd1);
          cmd_ba_d   = addr_q[AVL_A_W-1 -: MCB_B_W];
          cmd_ra_d   = addr_q[MCB_C_W +: MCB_R_W];
          cmd_ca_d   = {addr_q[MCB_C_W-1:2], 2'b00};
          push       = rd_q;
          w_grp_d    = seg_grp_q;
          w_off_d    = seg_off_q;
          w_vld_d    = seg_vld_q;
          k_d        = '0;
          first_d    = 1'b0;
          // Flat add: column overflow carries into row, row into bank, top bank wraps.
          addr_d     = addr_q + AVL_A_W'(seg_vld_q);
          rem_d      = rem_q - AVL_BC_W'(seg_vld_q);
          if (!rd_q) st_d = ST_WDAT;
          else if (rem_d == '0) st_d = ST_IDLE;
        end
      end
      ST_WDAT: begin
        if (mcb_wdat_req) begin
          wact_d = 1'b1;
          wval_d = in_win(k_q, w_off_q, w_vld_q);
          k_d    = k_q + 4'd1;
          if (k_q == {2'(w_grp_q - 3'd1), 2'b11}) begin
            k_d  = '0;
            st_d = (rem_q != '0) ? ST_ISSUE : ST_IDLE;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Read return runs off the FIFO head regardless of the command FSM.
  always_comb begin
    rdv_d = 1'b0; rdata_d = rdata_q; j_d = j_q; err_d = err_q; pop = 1'b0;
    if (mcb_rdat_vld) begin
      if (fifo_empty) begin
        err_d = 1'b1;
      end else begin
        if (in_win(j_q, head[6:5], head[4:0])) begin
          rdv_d   = 1'b1;
          rdata_d = mcb_rdat;
        end
        if (j_q == {2'(head[9:7] - 3'd1), 2'b11}) begin
          pop = 1'b1;
          j_d = '0;
        end else begin
          j_d = j_q + 4'd1;
        end
      end
    end
    wptr_d = wptr_q + {{PTR_W{1'b0}}, push};
    rptr_d = rptr_q + {{PTR_W{1'b0}}, pop};
  end

  always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
    if (csi_clockreset_reset) begin
      st_q <= ST_IDLE; addr_q <= '0; rem_q <= '0; rd_q <= 1'b0; first_q <= 1'b0;
      seg_grp_q <= '0; seg_off_q <= '0; seg_vld_q <= '0;
      w_grp_q <= '0; w_off_q <= '0; w_vld_q <= '0; k_q <= '0; j_q <= '0;
      wact_q <= 1'b0; wval_q <= 1'b0;
      cmd_bb_q <= 1'b0; cmd_wr_n_q <= 1'b0; cmd_bl_q <= '0;
      cmd_ba_q <= '0; cmd_ra_q <= '0; cmd_ca_q <= '0;
      rdv_q <= 1'b0; rdata_q <= '0; err_q <= 1'b0; wptr_q <= '0; rptr_q <= '0;
    end else begin
      st_q <= st_d; addr_q <= addr_d; rem_q <= rem_d; rd_q <= rd_d; first_q <= first_d;
      seg_grp_q <= seg_grp_d; seg_off_q <= seg_off_d; seg_vld_q <= seg_vld_d;
      w_grp_q <= w_grp_d; w_off_q <= w_off_d; w_vld_q <= w_vld_d; k_q <= k_d; j_q <= j_d;
      wact_q <= wact_d; wval_q <= wval_d;
      cmd_bb_q <= cmd_bb_d; cmd_wr_n_q <= cmd_wr_n_d; cmd_bl_q <= cmd_bl_d;
      cmd_ba_q <= cmd_ba_d; cmd_ra_q <= cmd_ra_d; cmd_ca_q <= cmd_ca_d;
      rdv_q <= rdv_d; rdata_q <= rdata_d; err_q <= err_d; wptr_q <= wptr_d; rptr_q <= rptr_d;
    end
  end

  // Tag storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge csi_clockreset_clk) begin
    if (push) mem_q[wptr_q[PTR_W-1:0]] <= {seg_grp_q, seg_off_q, seg_vld_q};
  end

  // Continuation read segments consume no master beat, so they pass without a stall.
  assign avs_s1_waitrequest = ~mcb_i_ready |
                              ~(accept | (wact_q & wval_q) | (fire & rd_q & ~first_q));
  assign mcb_wdat = (wact_q & wval_q) ? avs_s1_writedata : '0;
  assign mcb_wbe  = (wact_q & wval_q) ? avs_s1_byteenable : '0;

  assign mcb_bb   = cmd_bb_q;
  assign mcb_wr_n = cmd_wr_n_q;
  assign mcb_bl   = cmd_bl_q;
  assign mcb_ba   = cmd_ba_q;
  assign mcb_ra   = cmd_ra_q;
  assign mcb_ca   = cmd_ca_q;
  assign avs_s1_readdata      = rdata_q;
  assign avs_s1_readdatavalid = rdv_q;
  assign err_unexp_rdat       = err_q;

endmodule

// File: tb/tb_mcb_avl_wrap_seg.sv
// Directed self-checking bench for mcb_avl_wrap_seg.
module tb_mcb_avl_wrap_seg;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] address;
  logic        read, write, bbt;
  logic [5:0]  burstcount;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        mcb_bb, mcb_wr_n;
  logic [1:0]  mcb_bl;
  logic [1:0]  mcb_ba;
  logic [12:0] mcb_ra;
  logic [8:0]  mcb_ca;
  logic        mcb_busy, mcb_i_ready, mcb_wdat_req;
  logic [31:0] mcb_wdat;
  logic [3:0]  mcb_wbe;
  logic        mcb_rdat_vld;
  logic [31:0] mcb_rdat;
  logic        err_unexp_rdat;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] be_tab [4] = '{4'hF, 4'h3, 4'hC, 4'h9};

  always #5 clk = ~clk;

  mcb_avl_wrap_seg dut (
    .csi_clockreset_clk        (clk),
    .csi_clockreset_reset      (rst),
    .avs_s1_address            (address),
    .avs_s1_read               (read),
    .avs_s1_write              (write),
    .avs_s1_beginbursttransfer (bbt),
    .avs_s1_burstcount         (burstcount),
    .avs_s1_writedata          (writedata),
    .avs_s1_byteenable         (byteenable),
    .avs_s1_waitrequest        (waitrequest),
    .avs_s1_readdata           (readdata),
    .avs_s1_readdatavalid      (readdatavalid),
    .mcb_bb                    (mcb_bb),
    .mcb_wr_n                  (mcb_wr_n),
    .mcb_bl                    (mcb_bl),
    .mcb_ba                    (mcb_ba),
    .mcb_ra                    (mcb_ra),
    .mcb_ca                    (mcb_ca),
    .mcb_busy                  (mcb_busy),
    .mcb_i_ready               (mcb_i_ready),
    .mcb_wdat_req              (mcb_wdat_req),
    .mcb_wdat                  (mcb_wdat),
    .mcb_wbe                   (mcb_wbe),
    .mcb_rdat_vld              (mcb_rdat_vld),
    .mcb_rdat                  (mcb_rdat),
    .err_unexp_rdat            (err_unexp_rdat)
  );

  function automatic logic [23:0] mk_addr(input logic [1:0] ba, input logic [12:0] ra,
                                          input logic [8:0] ca);
    return {ba, ra, ca};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_burst(input logic is_rd, input logic [23:0] a, input logic [5:0] n);
    address = a; read = is_rd; write = ~is_rd; bbt = 1'b1; burstcount = n;
    #1;
  endtask

  task automatic end_burst();
    read = 1'b0; write = 1'b0; bbt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; address = '0; read = 0; write = 0; bbt = 0; burstcount = '0;
    writedata = '0; byteenable = '0; mcb_busy = 0; mcb_i_ready = 1; mcb_wdat_req = 0;
    mcb_rdat_vld = 0; mcb_rdat = '0;
    tick(); tick();
    n_checks++; if (mcb_bb !== 1'b0) $display("FAIL rst_bb: got %0b want 0", mcb_bb); else n_pass++;
    n_checks++; if ({mcb_wr_n, mcb_bl, mcb_ba, mcb_ra, mcb_ca} !== '0)
      $display("FAIL rst_cmd: got %h want 0", {mcb_wr_n, mcb_bl, mcb_ba, mcb_ra, mcb_ca});
    else n_pass++;
    n_checks++; if (mcb_wbe !== 4'h0) $display("FAIL rst_wbe: got %h want 0", mcb_wbe); else n_pass++;
    n_checks++; if (readdatavalid !== 1'b0 || readdata !== 32'h0)
      $display("FAIL rst_rd: got %0b/%h want 0/0", readdatavalid, readdata); else n_pass++;
    n_checks++; if (err_unexp_rdat !== 1'b0) $display("FAIL rst_err: got %0b want 0", err_unexp_rdat);
    else n_pass++;
    n_checks++; if (waitrequest !== 1'b1) $display("FAIL rst_wait: got %0b want 1", waitrequest);
    else n_pass++;
    rst = 1'b0;
    tick();
    // Zero burstcount is ignored
    begin_burst(1'b0, mk_addr(0, 0, 0), 6'd0);
    n_checks++; if (waitrequest !== 1'b1) $display("FAIL bc0_wait: got %0b want 1", waitrequest);
    else n_pass++;
    tick(); end_burst(); tick(); tick();
    n_checks++; if (mcb_bb !== 1'b0) $display("FAIL bc0_bb: got %0b want 0", mcb_bb); else n_pass++;
  endtask

  task automatic test_write4();
    int nlow;
    begin_burst(1'b0, mk_addr(0, 0, 0), 6'd4);
    n_checks++; if (waitrequest !== 1'b0) $display("FAIL w4_accept: got %0b want 0", waitrequest);
    else n_pass++;
    tick(); end_burst(); #1;
    n_checks++; if (waitrequest !== 1'b1) $display("FAIL w4_issue_wait: got %0b want 1", waitrequest);
    else n_pass++;
    tick();
    n_checks++; if ({mcb_bb, mcb_wr_n, mcb_bl, mcb_ca} !== {1'b1, 1'b0, 2'd0, 9'd0})
      $display("FAIL w4_cmd: got bb%0b wrn%0b bl%0d ca%0d want bb1 wrn0 bl0 ca0",
               mcb_bb, mcb_wr_n, mcb_bl, mcb_ca);
    else n_pass++;
    nlow = 0;
    for (int i = 0; i < 4; i++) begin
      mcb_wdat_req = 1'b1;
      tick();
      if (i == 3) mcb_wdat_req = 1'b0;
      writedata = 32'hA5A5_0000 + 32'(i); byteenable = be_tab[i];
      #1;
      n_checks++; if (mcb_wbe !== be_tab[i] || mcb_wdat !== writedata)
        $display("FAIL w4_beat%0d: got %h/%h want %h/%h", i, mcb_wbe, mcb_wdat, be_tab[i], writedata);
      else n_pass++;
      if (!waitrequest) nlow++;
    end
    tick();
    if (!waitrequest) nlow++;
    n_checks++; if (mcb_wbe !== 4'h0) $display("FAIL w4_after_wbe: got %h want 0", mcb_wbe);
    else n_pass++;
    n_checks++; if (nlow !== 4) $display("FAIL w4_wait_low: got %0d want 4", nlow); else n_pass++;
  endtask

  task automatic test_write10();
    logic valid;
    begin_burst(1'b0, mk_addr(0, 5, 510), 6'd10);
    n_checks++; if (waitrequest !== 1'b0) $display("FAIL w10_accept: got %0b want 0", waitrequest);
    else n_pass++;
    tick(); end_burst(); tick();
    n_checks++; if ({mcb_bb, mcb_bl, mcb_ra, mcb_ca} !== {1'b1, 2'd0, 13'd5, 9'd508})
      $display("FAIL w10_cmd1: got bb%0b bl%0d ra%0d ca%0d want bb1 bl0 ra5 ca508",
               mcb_bb, mcb_bl, mcb_ra, mcb_ca);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      mcb_wdat_req = 1'b1;
      tick();
      if (i == 3) mcb_wdat_req = 1'b0;
      writedata = 32'hB000_0000 + 32'(i); byteenable = be_tab[i];
      #1;
      valid = (i >= 2);
      n_checks++; if (mcb_wbe !== (valid ? be_tab[i] : 4'h0) || waitrequest !== ~valid)
        $display("FAIL w10_c1_beat%0d: got wbe %h wait %0b want wbe %h wait %0b", i, mcb_wbe,
                 waitrequest, valid ? be_tab[i] : 4'h0, ~valid);
      else n_pass++;
    end
    tick();
    n_checks++; if ({mcb_bb, mcb_bl, mcb_ra, mcb_ca} !== {1'b1, 2'd1, 13'd6, 9'd0})
      $display("FAIL w10_cmd2: got bb%0b bl%0d ra%0d ca%0d want bb1 bl1 ra6 ca0",
               mcb_bb, mcb_bl, mcb_ra, mcb_ca);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      mcb_wdat_req = 1'b1;
      tick();
      if (i == 7) mcb_wdat_req = 1'b0;
      writedata = 32'hC000_0000 + 32'(i); byteenable = be_tab[i % 4];
      #1;
      n_checks++; if (mcb_wbe !== be_tab[i % 4] || mcb_wdat !== writedata || waitrequest !== 1'b0)
        $display("FAIL w10_c2_beat%0d: got wbe %h dat %h wait %0b want wbe %h dat %h wait 0", i,
                 mcb_wbe, mcb_wdat, waitrequest, be_tab[i % 4], writedata);
      else n_pass++;
    end
    tick();
    n_checks++; if (mcb_wbe !== 4'h0 || mcb_bb !== 1'b0)
      $display("FAIL w10_end: got wbe %h bb %0b want 0 0", mcb_wbe, mcb_bb); else n_pass++;
  endtask

  task automatic test_read63();
    int cnt;
    logic exp;
    begin_burst(1'b1, mk_addr(1, 2, 0), 6'd63);
    n_checks++; if (waitrequest !== 1'b0) $display("FAIL r63_accept: got %0b want 0", waitrequest);
    else n_pass++;
    tick(); end_burst(); #1;
    n_checks++; if (waitrequest !== 1'b1) $display("FAIL r63_first_wait: got %0b want 1", waitrequest);
    else n_pass++;
    for (int s = 0; s < 4; s++) begin
      tick();
      n_checks++; if ({mcb_bb, mcb_wr_n, mcb_bl, mcb_ba, mcb_ra, mcb_ca} !==
                      {1'b1, 1'b1, 2'd3, 2'd1, 13'd2, 9'(16 * s)})
        $display("FAIL r63_cmd%0d: got bb%0b wrn%0b bl%0d ba%0d ra%0d ca%0d want bb1 wrn1 bl3 ba1 ra2 ca%0d",
                 s, mcb_bb, mcb_wr_n, mcb_bl, mcb_ba, mcb_ra, mcb_ca, 16 * s);
      else n_pass++;
      if (s < 3) begin
        n_checks++; if (waitrequest !== 1'b0)
          $display("FAIL r63_cont_wait%0d: got %0b want 0", s, waitrequest);
        else n_pass++;
      end
    end
    tick();
    n_checks++; if (mcb_bb !== 1'b0) $display("FAIL r63_no_cmd5: got %0b want 0", mcb_bb); else n_pass++;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      mcb_rdat_vld = 1'b1; mcb_rdat = 32'hD000_0000 + 32'(i);
      tick();
      exp = (i != 63);
      if (readdatavalid) cnt++;
      n_checks++; if (readdatavalid !== exp || (exp && readdata !== mcb_rdat))
        $display("FAIL r63_beat%0d: got v%0b d%h want v%0b d%h", i, readdatavalid, readdata, exp,
                 mcb_rdat);
      else n_pass++;
    end
    mcb_rdat_vld = 1'b0;
    n_checks++; if (cnt !== 63) $display("FAIL r63_count: got %0d want 63", cnt); else n_pass++;
  endtask

  task automatic test_read3_off1();
    logic exp;
    begin_burst(1'b1, mk_addr(0, 7, 1), 6'd3);
    tick(); end_burst(); tick();
    n_checks++; if ({mcb_bb, mcb_bl, mcb_ra, mcb_ca} !== {1'b1, 2'd0, 13'd7, 9'd0})
      $display("FAIL r3_cmd: got bb%0b bl%0d ra%0d ca%0d want bb1 bl0 ra7 ca0",
               mcb_bb, mcb_bl, mcb_ra, mcb_ca);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      mcb_rdat_vld = 1'b1; mcb_rdat = 32'hE000_0000 + 32'(i);
      tick();
      exp = (i >= 1);
      n_checks++; if (readdatavalid !== exp || (exp && readdata !== mcb_rdat))
        $display("FAIL r3_beat%0d: got v%0b d%h want v%0b d%h", i, readdatavalid, readdata, exp,
                 mcb_rdat);
      else n_pass++;
    end
    mcb_rdat_vld = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cnt;
    for (int n = 0; n < 9; n++) begin
      begin_burst(1'b1, mk_addr(0, 13'(n), 0), 6'd1);
      n_checks++; if (waitrequest !== 1'b0) $display("FAIL b2b_accept%0d: got %0b want 0", n, waitrequest);
      else n_pass++;
      tick(); end_burst(); tick();
      n_checks++; if (mcb_bb !== (n < 8))
        $display("FAIL b2b_cmd%0d: got bb%0b want %0b", n, mcb_bb, n < 8);
      else n_pass++;
    end
    tick(); tick();
    n_checks++; if (mcb_bb !== 1'b0 || waitrequest !== 1'b1)
      $display("FAIL b2b_stall: got bb%0b wait%0b want bb0 wait1", mcb_bb, waitrequest);
    else n_pass++;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      mcb_rdat_vld = 1'b1; mcb_rdat = 32'h1000 + 32'(i);
      tick();
      if (readdatavalid) cnt++;
    end
    mcb_rdat_vld = 1'b0;
    n_checks++; if (mcb_bb !== 1'b0) $display("FAIL b2b_pre_pop_bb: got %0b want 0", mcb_bb); else n_pass++;
    tick();
    n_checks++; if (mcb_bb !== 1'b1 || mcb_ra !== 13'd8)
      $display("FAIL b2b_cmd9: got bb%0b ra%0d want bb1 ra8", mcb_bb, mcb_ra);
    else n_pass++;
    n_checks++; if (cnt !== 1) $display("FAIL b2b_first_cnt: got %0d want 1", cnt); else n_pass++;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      mcb_rdat_vld = 1'b1; mcb_rdat = 32'h2000 + 32'(i);
      tick();
      if (readdatavalid) cnt++;
    end
    mcb_rdat_vld = 1'b0;
    n_checks++; if (cnt !== 8) $display("FAIL b2b_drain_cnt: got %0d want 8", cnt); else n_pass++;
  endtask

  task automatic test_unexp();
    tick();
    mcb_rdat_vld = 1'b1; mcb_rdat = 32'hDEAD_BEEF;
    tick();
    mcb_rdat_vld = 1'b0;
    n_checks++; if (readdatavalid !== 1'b0 || err_unexp_rdat !== 1'b1)
      $display("FAIL unexp: got v%0b err%0b want v0 err1", readdatavalid, err_unexp_rdat);
    else n_pass++;
    tick(); tick();
    n_checks++; if (err_unexp_rdat !== 1'b1) $display("FAIL unexp_sticky: got %0b want 1", err_unexp_rdat);
    else n_pass++;
  endtask

  task automatic test_reset_midwrite();
    begin_burst(1'b0, mk_addr(0, 1, 0), 6'd4);
    tick(); end_burst(); tick();
    mcb_wdat_req = 1'b1;
    tick();
    mcb_wdat_req = 1'b0; writedata = 32'h1234_5678; byteenable = 4'hF;
    #1;
    n_checks++; if (mcb_wbe !== 4'hF) $display("FAIL mid_pre_wbe: got %h want f", mcb_wbe); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (mcb_wbe !== 4'h0 || mcb_wdat !== 32'h0 || mcb_bb !== 1'b0)
      $display("FAIL mid_rst_w: got wbe%h dat%h bb%0b want 0 0 0", mcb_wbe, mcb_wdat, mcb_bb);
    else n_pass++;
    n_checks++; if (err_unexp_rdat !== 1'b0 || readdata !== 32'h0 || mcb_ra !== 13'd0)
      $display("FAIL mid_rst_regs: got err%0b rd%h ra%0d want 0 0 0", err_unexp_rdat, readdata, mcb_ra);
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    begin_burst(1'b0, mk_addr(0, 3, 4), 6'd1);
    tick(); end_burst(); tick();
    n_checks++; if ({mcb_bb, mcb_bl, mcb_ra, mcb_ca} !== {1'b1, 2'd0, 13'd3, 9'd4})
      $display("FAIL post_rst_cmd: got bb%0b bl%0d ra%0d ca%0d want bb1 bl0 ra3 ca4",
               mcb_bb, mcb_bl, mcb_ra, mcb_ca);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write4();
    test_write10();
    test_read63();
    test_read3_off1();
    test_back_to_back();
    test_unexp();
    test_reset_midwrite();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
